// File: rtl/board_pkg.sv
// Shared playfield geometry and clear-engine state encoding for board_mem,
// the game logic FSM and the VGA renderer.
package board_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;
    localparam int L_W     = 5;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SCAN  = 2'd1,
        CLR_SHIFT = 2'd2,
        CLR_DONE  = 2'd3
    } clr_state_t;

    function automatic logic in_board(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(BOARD_W)) && (y < Y_W'(BOARD_H));
    endfunction

endpackage

// File: rtl/board_clear_fsm.sv
// Line-clear sequencer: walks rows bottom-up, requests a one-edge stack shift
// for every full row and counts the rows removed.
module board_clear_fsm
    import board_pkg::*;
(
    input  logic           clk,
    input  logic           srst,
    input  logic           start,
    input  logic           row_full,
    input  logic           above_full,
    output logic           busy,
    output logic           done,
    output logic           shift_en,
    output logic [Y_W-1:0] row_sel,
    output logic [L_W-1:0] lines
);

    clr_state_t     state_reg, state_next;
    logic [Y_W-1:0] row_reg, row_next;
    logic [L_W-1:0] lines_reg, lines_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= CLR_IDLE;
            row_reg   <= Y_W'(BOARD_H - 1);
            lines_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            lines_reg <= lines_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        lines_next = lines_reg;
        shift_en   = 1'b0;
        busy       = (state_reg != CLR_IDLE);
        done       = (state_reg == CLR_DONE);
        case (state_reg)
            CLR_IDLE: begin
                if (start) begin
                    state_next = CLR_SCAN;
                    row_next   = Y_W'(BOARD_H - 1);
                    lines_next = '0;
                end
            end
            CLR_SCAN: begin
                if (row_full) begin
                    state_next = CLR_SHIFT;
                end else if (row_reg == '0) begin
                    state_next = CLR_DONE;
                end else begin
                    row_next = row_reg - 1'b1;
                end
            end
            CLR_SHIFT: begin
                // The row dropping into row_reg is judged during the shift
                // itself, so each removed row costs exactly one extra cycle.
                shift_en   = 1'b1;
                lines_next = lines_reg + 1'b1;
                if (above_full) begin
                    state_next = CLR_SHIFT;
                end else if (row_reg == '0) begin
                    state_next = CLR_DONE;
                end else begin
                    state_next = CLR_SCAN;
                    row_next   = row_reg - 1'b1;
                end
            end
            CLR_DONE: begin
                state_next = CLR_IDLE;
            end
            default: begin
                state_next = CLR_IDLE;
            end
        endcase
    end

    assign row_sel = row_reg;
    assign lines   = lines_reg;

endmodule

// File: rtl/board_mem.sv
// 10x20 playfield occupancy store with game and renderer read ports and a
// line-clear engine; the engine is built only when BOARD_CLEAR_EN is defined.
module board_mem
    import board_pkg::*;
(
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic [X_W-1:0] board_rx,
    input  logic [Y_W-1:0] board_ry,
    output logic           board_rdata,
    input  logic           board_we,
    input  logic [X_W-1:0] board_wx,
    input  logic [Y_W-1:0] board_wy,
    input  logic           board_wdata,
    input  logic [X_W-1:0] vga_x,
    input  logic [Y_W-1:0] vga_y,
    output logic           vga_rdata,
    input  logic           clr_start,
    output logic           clr_busy,
    output logic           clr_done,
    output logic [L_W-1:0] clr_lines
);

    logic [BOARD_H-1:0][BOARD_W-1:0] rows;
    logic                            shift_en;
    logic [Y_W-1:0]                  row_sel;
    logic                            wr_en;

    assign wr_en = board_we && !clr_busy && in_board(board_wx, board_wy);

`ifdef BOARD_CLEAR_EN
    logic row_full;
    logic above_full;

    assign row_full   = &rows[row_sel];
    assign above_full = (row_sel != '0) && (&rows[row_sel - 1'b1]);

    board_clear_fsm u_clear_fsm (
        .clk        (CLOCK_50),
        .srst       (reset),
        .start      (clr_start),
        .row_full   (row_full),
        .above_full (above_full),
        .busy       (clr_busy),
        .done       (clr_done),
        .shift_en   (shift_en),
        .row_sel    (row_sel),
        .lines      (clr_lines)
    );
`else
    // Without the engine a request is simply acknowledged one cycle later.
    logic done_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= clr_start && !done_reg;
        end
    end

    assign clr_busy  = done_reg;
    assign clr_done  = done_reg;
    assign clr_lines = '0;
    assign shift_en  = 1'b0;
    assign row_sel   = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < BOARD_H; gi++) begin : g_row
            logic [BOARD_W-1:0] row_reg;
            logic [BOARD_W-1:0] row_above;

            if (gi == 0) begin : g_top
                assign row_above = '0;
            end else begin : g_inner
                assign row_above = rows[gi-1];
            end

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    row_reg <= '0;
                end else if (shift_en && (Y_W'(gi) <= row_sel)) begin
                    row_reg <= row_above;
                end else if (wr_en && (board_wy == Y_W'(gi))) begin
                    row_reg[board_wx] <= board_wdata;
                end
            end

            assign rows[gi] = row_reg;
        end
    endgenerate

    // Off-board reads look like wall to the game and empty to the renderer.
    assign board_rdata = in_board(board_rx, board_ry) ? rows[board_ry][board_rx] : 1'b1;
    assign vga_rdata   = in_board(vga_x, vga_y) ? rows[vga_y][vga_x] : 1'b0;

endmodule

// File: tb/tb_board_mem.sv
// Randomized and directed bench for board_mem against a row-list playfield model.
module tb_board_mem;

`ifdef BOARD_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] board_rx, board_wx, vga_x;
    logic [4:0] board_ry, board_wy, vga_y;
    logic       board_rdata, vga_rdata;
    logic       board_we, board_wdata;
    logic       clr_start, clr_busy, clr_done;
    logic [4:0] clr_lines;

    int n_cmp = 0;
    int n_err = 0;
    bit [9:0] model [20];
    int exp_lines = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    board_mem dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .board_rx    (board_rx),
        .board_ry    (board_ry),
        .board_rdata (board_rdata),
        .board_we    (board_we),
        .board_wx    (board_wx),
        .board_wy    (board_wy),
        .board_wdata (board_wdata),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_rdata   (vga_rdata),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .clr_lines   (clr_lines)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic bit exp_game(input int x, input int y);
        if (x > 9 || y > 19) return 1'b1;
        return model[y][x];
    endfunction

    function automatic bit exp_vga(input int x, input int y);
        if (x > 9 || y > 19) return 1'b0;
        return model[y][x];
    endfunction

    // Removes every full row and lets the remaining rows fall in order.
    function automatic int model_clear();
        bit [9:0] kept [$];
        int k = 0;
        for (int y = 19; y >= 0; y--) begin
            if (model[y] == 10'h3FF) k++;
            else kept.push_back(model[y]);
        end
        for (int y = 19; y >= 0; y--) begin
            model[y] = (kept.size() > 0) ? kept.pop_front() : 10'h000;
        end
        return k;
    endfunction

    task automatic read_pair(input string tag, input int x, input int y);
        board_rx = 4'(x); board_ry = 5'(y);
        vga_x    = 4'(x); vga_y    = 5'(y);
        @(negedge CLOCK_50);
        check({tag, "_game"}, board_rdata, exp_game(x, y));
        check({tag, "_vga"}, vga_rdata, exp_vga(x, y));
        tick();
    endtask

    task automatic dump_check(input string tag);
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                read_pair(tag, x, y);
    endtask

    task automatic write_cell(input int x, input int y, input bit d);
        board_we = 1'b1; board_wx = 4'(x); board_wy = 5'(y); board_wdata = d;
        tick();
        board_we = 1'b0;
        if (x <= 9 && y <= 19) model[y][x] = d;
    endtask

    task automatic fill_row(input int y);
        for (int x = 0; x < 10; x++) write_cell(x, y, 1'b1);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            int rx, ry, wx, wy;
            bit we, wd;
            rx = $urandom_range(0, 11); ry = $urandom_range(0, 21);
            wx = $urandom_range(0, 11); wy = $urandom_range(0, 21);
            we = 1'($urandom); wd = 1'($urandom);
            board_rx = 4'(rx); board_ry = 5'(ry);
            vga_x = 4'(rx); vga_y = 5'(ry);
            board_we = we; board_wx = 4'(wx); board_wy = 5'(wy); board_wdata = wd;
            @(negedge CLOCK_50);
            check("rand_game", board_rdata, exp_game(rx, ry));
            check("rand_vga", vga_rdata, exp_vga(rx, ry));
            tick();
            if (we && wx <= 9 && wy <= 19) model[wy][wx] = wd;
        end
        board_we = 1'b0;
    endtask

    task automatic reset_model();
        for (int y = 0; y < 20; y++) model[y] = '0;
        exp_lines = 0;
    endtask

    // Issues a clear at cycle 0 with junk traffic while busy; abort_at > 0
    // asserts reset during that cycle.
    task automatic run_clear(input bit with_write, input int abort_at);
        int k, total, wx, wy;
        bit wd;
        wx = $urandom_range(0, 9); wy = $urandom_range(0, 19); wd = 1'($urandom);
        clr_start = 1'b1;
        board_we = with_write; board_wx = 4'(wx); board_wy = 5'(wy); board_wdata = wd;
        @(negedge CLOCK_50);
        check("c0_busy", clr_busy, 1'b0);
        check("c0_done", clr_done, 1'b0);
        tick();
        if (with_write) model[wy][wx] = wd;
        clr_start = 1'b0;
        board_we = 1'b0;
        k = CLR_EN ? model_clear() : 0;
        total = CLR_EN ? 21 + k : 1;
        for (int c = 1; c <= total + 2; c++) begin
            bit junk;
            junk = (c <= total);
            clr_start = junk ? 1'($urandom) : 1'b0;
            board_we = junk ? 1'($urandom) : 1'b0;
            board_wx = 4'($urandom_range(0, 9));
            board_wy = 5'($urandom_range(0, 19));
            board_wdata = 1'($urandom);
            if (c == abort_at) reset = 1'b1;
            @(negedge CLOCK_50);
            check("clr_busy", clr_busy, c <= total);
            check("clr_done", clr_done, c == total);
            tick();
            if (c == abort_at) begin
                reset = 1'b0;
                clr_start = 1'b0;
                board_we = 1'b0;
                reset_model();
                @(negedge CLOCK_50);
                check("abort_busy", clr_busy, 1'b0);
                check("abort_done", clr_done, 1'b0);
                check("abort_lines", clr_lines, 5'd0);
                tick();
                for (int j = 0; j < 30; j++) begin
                    @(negedge CLOCK_50);
                    check("abort_nodone", clr_done, 1'b0);
                    tick();
                end
                return;
            end
        end
        clr_start = 1'b0;
        board_we = 1'b0;
        exp_lines = k;
        @(negedge CLOCK_50);
        check("clr_lines", clr_lines, 5'(exp_lines));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        board_rx = '0; board_ry = '0; vga_x = '0; vga_y = '0;
        board_we = 1'b0; board_wx = '0; board_wy = '0; board_wdata = 1'b0;
        clr_start = 1'b0;
        reset_model();
        tick(); tick();
        reset = 1'b0;

        @(negedge CLOCK_50);
        check("rst_busy", clr_busy, 1'b0);
        check("rst_done", clr_done, 1'b0);
        check("rst_lines", clr_lines, 5'd0);
        tick();
        dump_check("rst_cell");

        write_cell(3, 19, 1'b1);
        read_pair("w3_19", 3, 19);
        read_pair("oob_x10", 10, 5);
        read_pair("oob_y20", 0, 20);
        read_pair("oob_x15", 15, 31);
        write_cell(3, 19, 1'b0);
        write_cell(12, 3, 1'b1);
        read_pair("oob_wr_ignored", 2, 3);

        run_clear(1'b0, 0);
        dump_check("empty_clear");

        fill_row(19);
        write_cell(2, 18, 1'b1);
        run_clear(1'b0, 0);
        dump_check("one_row");

        reset = 1'b1; tick(); reset = 1'b0; reset_model();
        for (int y = 16; y <= 19; y++) fill_row(y);
        write_cell(7, 15, 1'b1);
        write_cell(7, 15, 1'b0);
        run_clear(1'b0, 0);
        dump_check("four_rows");
        @(negedge CLOCK_50);
        check("lines_hold", clr_lines, 5'(exp_lines));
        tick();

        for (int round = 0; round < 4; round++) begin
            random_cycles(25);
            for (int y = 12; y <= 19; y++)
                if ($urandom_range(0, 1) == 1) fill_row(y);
            fill_row(0);
            run_clear(1'b1, 0);
            dump_check("rand_clear");
        end

        fill_row(19);
        fill_row(17);
        run_clear(1'b0, 5);
        dump_check("abort_cell");

        random_cycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
